// File: rtl/sic_exec_alu_q.sv
// In-order issue queue plus executor for one SIC: commits the head through the shared
// ALU lock, RF commit port and ECR table, and aborts heads whose branch dependency mispredicted.
package sic_exec_alu_q_pkg;
   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2, WB_NONE = 2'd3
   } wb_sel_t;

   // Field widths cover the largest supported configuration; the executor slices what it needs.
   typedef struct packed {
      logic [15:0] issue_id;
      alu_op_t     alu_op;
      logic        use_alu;
      logic        read_rs;
      logic        read_rt;
      logic [7:0]  rs_addr;
      logic [7:0]  rt_addr;
      logic [7:0]  rd_addr;
      logic [15:0] imm16;
      logic        alu_b_is_imm;
      logic        zero_ext;
      logic        write_gpr;
      wb_sel_t     wb_sel;
      logic        write_ecr;
      logic [7:0]  set_ecr_id;
      logic [7:0]  dep_ecr_id;
      logic        pred_taken;
   } sic_packet_t;
endpackage

module sic_exec_alu_q
   import sic_exec_alu_q_pkg::*;
#(
   parameter int SIC_ID       = 0,
   parameter int NUM_PHY_REGS = 64,
   parameter int NUM_ECRS     = 4,
   parameter int ID_WIDTH     = 8,
   parameter int DEPTH        = 4,
   parameter int FLUSH_ALL    = 1,
   parameter int CNT_W        = 16,
   localparam int ECR_W       = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1,
   localparam int OCC_W       = $clog2(DEPTH + 1)
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  sic_packet_t         in_pkt,
   output logic                head_valid,
   output sic_packet_t         head_pkt,
   input  logic                rs_valid,
   input  logic                rt_valid,
   input  logic [31:0]         rs_rdata,
   input  logic [31:0]         rt_rdata,
   output logic                ecr_read_en,
   output logic [ECR_W-1:0]    ecr_read_addr,
   input  logic [1:0]          ecr_read_data,
   output logic                alu_lock_req,
   output logic [ID_WIDTH-1:0] alu_lock_id,
   output logic                alu_release,
   input  logic                alu_grant,
   output alu_op_t             alu_op,
   output logic [31:0]         alu_a,
   output logic [31:0]         alu_b,
   input  logic [31:0]         alu_c,
   input  logic                alu_zero,
   output logic                rf_wcommit,
   output logic [31:0]         rf_wdata,
   output logic                ecr_wen,
   output logic [ECR_W-1:0]    ecr_waddr,
   output logic [1:0]          ecr_wdata,
   output logic [OCC_W-1:0]    occupancy,
   output logic [CNT_W-1:0]    commit_cnt,
   output logic [CNT_W-1:0]    abort_cnt
);
   localparam int PTR_W = $clog2(DEPTH);

   if (NUM_PHY_REGS > 256 || ID_WIDTH > 16 || NUM_ECRS > 128) begin : g_bad_cfg
      $error("sic_exec_alu_q %0d: configuration exceeds packet field widths", SIC_ID);
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + 1'b1 : v;
   endfunction

   sic_packet_t      r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd, r_wr;
   logic [OCC_W-1:0] r_count;
   logic             r_release;
   logic [CNT_W-1:0] r_commit_cnt, r_abort_cnt;

   sic_packet_t      w_head;
   logic             w_valid, w_need_alu, w_rf_ok, w_dep, w_ecr_ok;
   logic             w_abort, w_commit, w_push, w_pop, w_flush;
   logic [31:0]      w_imm_ext;

   assign w_head     = r_mem[r_rd];
   assign w_valid    = (r_count != '0);
   assign w_need_alu = w_valid & w_head.use_alu;
   assign w_rf_ok    = (!w_head.read_rs | rs_valid) & (!w_head.read_rt | rt_valid);
   assign w_dep      = w_head.dep_ecr_id[ECR_W];
   assign w_ecr_ok   = !w_dep | (ecr_read_data == 2'b01);
   assign w_abort    = w_valid & w_dep & (ecr_read_data == 2'b10);
   assign w_commit   = w_valid & w_rf_ok & w_ecr_ok & (!w_need_alu | alu_grant) & !w_abort;

   assign w_push  = in_valid & in_ready;
   assign w_flush = w_abort & (FLUSH_ALL != 0);
   assign w_pop   = w_commit | (w_abort & (FLUSH_ALL == 0));

   assign w_imm_ext = w_head.zero_ext ? {16'h0000, w_head.imm16}
                                      : {{16{w_head.imm16[15]}}, w_head.imm16};

   assign in_ready      = (r_count < OCC_W'(DEPTH));
   assign head_valid    = w_valid;
   assign head_pkt      = w_head;
   assign occupancy     = r_count;
   assign ecr_read_en   = w_valid & w_dep;
   assign ecr_read_addr = w_head.dep_ecr_id[ECR_W-1:0];
   assign alu_lock_req  = w_need_alu & !w_abort;
   assign alu_lock_id   = w_head.issue_id[ID_WIDTH-1:0];
   assign alu_release   = r_release;
   assign alu_op        = w_head.alu_op;
   assign alu_a         = rs_rdata;
   assign alu_b         = w_head.alu_b_is_imm ? w_imm_ext : rt_rdata;
   assign rf_wcommit    = w_commit & w_head.write_gpr & (w_head.wb_sel == WB_ALU);
   assign rf_wdata      = alu_c;
   assign ecr_wen       = w_commit & w_head.write_ecr;
   assign ecr_waddr     = w_head.set_ecr_id[ECR_W-1:0];
   assign ecr_wdata     = (alu_zero == w_head.pred_taken) ? 2'b01 : 2'b10;
   assign commit_cnt    = r_commit_cnt;
   assign abort_cnt     = r_abort_cnt;

   // Queue storage carries no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push && !w_flush) r_mem[r_wr] <= in_pkt;
   end

   // A full flush also swallows any packet enqueued in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd         <= '0;
         r_wr         <= '0;
         r_count      <= '0;
         r_release    <= 1'b0;
         r_commit_cnt <= '0;
         r_abort_cnt  <= '0;
      end else begin
         if (w_flush) begin
            r_count <= '0;
            r_rd    <= r_wr;
         end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         end
         r_release    <= (w_commit | w_abort) & w_need_alu;
         r_commit_cnt <= sat_inc(r_commit_cnt, w_commit);
         r_abort_cnt  <= sat_inc(r_abort_cnt, w_abort);
      end
   end
endmodule

// File: tb/tb_sic_exec_alu_q.sv
// Directed bench: dut_a flushes the whole queue (16-bit counters), dut_b drops only the
// head (2-bit counters); both share one stimulus stream.
module tb_sic_exec_alu_q;
   import sic_exec_alu_q_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   sic_packet_t in_pkt;
   logic        rs_valid, rt_valid;
   logic [31:0] rs_rdata, rt_rdata;
   logic [1:0]  ecr_read_data;
   logic        alu_grant;
   logic [31:0] alu_c;
   logic        alu_zero;

   logic a_in_ready, a_head_valid, a_ecr_read_en, a_alu_lock_req, a_alu_release;
   logic a_rf_wcommit, a_ecr_wen;
   sic_packet_t a_head_pkt;
   logic [1:0]  a_ecr_read_addr, a_ecr_waddr, a_ecr_wdata;
   logic [7:0]  a_alu_lock_id;
   alu_op_t     a_alu_op;
   logic [31:0] a_alu_a, a_alu_b, a_rf_wdata;
   logic [2:0]  a_occupancy;
   logic [15:0] a_commit_cnt, a_abort_cnt;

   logic b_in_ready, b_head_valid, b_ecr_read_en, b_alu_lock_req, b_alu_release;
   logic b_rf_wcommit, b_ecr_wen;
   sic_packet_t b_head_pkt;
   logic [1:0]  b_ecr_read_addr, b_ecr_waddr, b_ecr_wdata;
   logic [7:0]  b_alu_lock_id;
   alu_op_t     b_alu_op;
   logic [31:0] b_alu_a, b_alu_b, b_rf_wdata;
   logic [2:0]  b_occupancy;
   logic [1:0]  b_commit_cnt, b_abort_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sic_exec_alu_q #(.DEPTH(4), .FLUSH_ALL(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_pkt(in_pkt),
      .head_valid(a_head_valid), .head_pkt(a_head_pkt), .rs_valid(rs_valid), .rt_valid(rt_valid),
      .rs_rdata(rs_rdata), .rt_rdata(rt_rdata), .ecr_read_en(a_ecr_read_en),
      .ecr_read_addr(a_ecr_read_addr), .ecr_read_data(ecr_read_data),
      .alu_lock_req(a_alu_lock_req), .alu_lock_id(a_alu_lock_id), .alu_release(a_alu_release),
      .alu_grant(alu_grant), .alu_op(a_alu_op), .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_c(alu_c),
      .alu_zero(alu_zero), .rf_wcommit(a_rf_wcommit), .rf_wdata(a_rf_wdata), .ecr_wen(a_ecr_wen),
      .ecr_waddr(a_ecr_waddr), .ecr_wdata(a_ecr_wdata), .occupancy(a_occupancy),
      .commit_cnt(a_commit_cnt), .abort_cnt(a_abort_cnt)
   );

   sic_exec_alu_q #(.DEPTH(4), .FLUSH_ALL(0), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_pkt(in_pkt),
      .head_valid(b_head_valid), .head_pkt(b_head_pkt), .rs_valid(rs_valid), .rt_valid(rt_valid),
      .rs_rdata(rs_rdata), .rt_rdata(rt_rdata), .ecr_read_en(b_ecr_read_en),
      .ecr_read_addr(b_ecr_read_addr), .ecr_read_data(ecr_read_data),
      .alu_lock_req(b_alu_lock_req), .alu_lock_id(b_alu_lock_id), .alu_release(b_alu_release),
      .alu_grant(alu_grant), .alu_op(b_alu_op), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_c(alu_c),
      .alu_zero(alu_zero), .rf_wcommit(b_rf_wcommit), .rf_wdata(b_rf_wdata), .ecr_wen(b_ecr_wen),
      .ecr_waddr(b_ecr_waddr), .ecr_wdata(b_ecr_wdata), .occupancy(b_occupancy),
      .commit_cnt(b_commit_cnt), .abort_cnt(b_abort_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   function automatic sic_packet_t mk(input logic [15:0] id, input logic [15:0] imm,
                                      input logic ecr_wr, input logic [7:0] set_id,
                                      input logic [7:0] dep, input logic pred);
      sic_packet_t p;
      p              = '0;
      p.issue_id     = id;
      p.alu_op       = ecr_wr ? ALU_SUB : ALU_ADD;
      p.use_alu      = 1'b1;
      p.read_rs      = 1'b1;
      p.imm16        = imm;
      p.alu_b_is_imm = 1'b1;
      p.write_gpr    = !ecr_wr;
      p.wb_sel       = WB_ALU;
      p.write_ecr    = ecr_wr;
      p.set_ecr_id   = set_id;
      p.dep_ecr_id   = dep;
      p.pred_taken   = pred;
      return p;
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_pkt = '0; rs_valid = 1'b0; rt_valid = 1'b0;
      rs_rdata = '0; rt_rdata = '0; ecr_read_data = 2'b00; alu_grant = 1'b0;
      alu_c = '0; alu_zero = 1'b0;

      // reset state
      #12;
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_head_valid", a_head_valid, 0);
      chk("rst_occupancy", a_occupancy, 0);
      chk("rst_lock_req", a_alu_lock_req, 0);
      chk("rst_rf_wcommit", a_rf_wcommit, 0);
      chk("rst_ecr_wen", a_ecr_wen, 0);
      chk("rst_ecr_read_en", a_ecr_read_en, 0);
      chk("rst_release", a_alu_release, 0);
      chk("rst_commit_cnt", a_commit_cnt, 0);
      chk("rst_abort_cnt", a_abort_cnt, 0);
      rst_n = 1'b1;
      cyc();

      // single ADD rs=5 imm=3, zero-wait grant
      in_valid = 1'b1; in_pkt = mk(16'd1, 16'd3, 1'b0, 8'h00, 8'h00, 1'b0);
      rs_valid = 1'b1; rs_rdata = 32'd5; alu_grant = 1'b1; alu_c = 32'd8;
      cyc();
      in_valid = 1'b0;
      settle();
      chk("t1_head_valid", a_head_valid, 1);
      chk("t1_lock_req", a_alu_lock_req, 1);
      chk("t1_alu_a", a_alu_a, 32'd5);
      chk("t1_alu_b", a_alu_b, 32'd3);
      chk("t1_rf_wcommit", a_rf_wcommit, 1);
      chk("t1_rf_wdata", a_rf_wdata, 32'd8);
      chk("t1_release_early", a_alu_release, 0);
      cyc(); settle();
      chk("t1_release", a_alu_release, 1);
      chk("t1_commit_cnt", a_commit_cnt, 1);
      chk("t1_occupancy", a_occupancy, 0);
      chk("t1_rf_wcommit_after", a_rf_wcommit, 0);
      cyc(); settle();
      chk("t1_release_end", a_alu_release, 0);

      // fill with operands not ready, then drain in order
      cyc();
      rs_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_pkt = mk(16'(20 + i), (i == 0) ? 16'hFFFD : 16'(i), 1'b0, 8'h00, 8'h00, 1'b0);
         cyc();
      end
      settle();
      chk("t2_in_ready_full", a_in_ready, 0);
      chk("t2_occupancy_a", a_occupancy, 4);
      chk("t2_occupancy_b", b_occupancy, 4);
      in_pkt = mk(16'd99, 16'd0, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc();
      in_valid = 1'b0;
      settle();
      chk("t2_occ_after_5th", a_occupancy, 4);
      chk("t2_head_id", a_head_pkt.issue_id, 20);
      chk("t2_sign_ext", a_alu_b, 32'hFFFF_FFFD);
      chk("t2_stall_commit", a_rf_wcommit, 0);
      cyc();
      rs_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t2_drain_commit", a_rf_wcommit, 1);
         chk("t2_drain_order", a_alu_lock_id, 20 + i);
         cyc();
      end
      settle();
      chk("t2_occ_empty", a_occupancy, 0);
      chk("t2_in_ready", a_in_ready, 1);
      chk("t2_release_b2b", a_alu_release, 1);
      chk("t2_commit_cnt_a", a_commit_cnt, 5);
      chk("t2_commit_cnt_sat_b", b_commit_cnt, 3);

      // mispredict: head depends on ECR 2 which resolves to 10
      pulse_reset();
      ecr_read_data = 2'b00;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_pkt = mk(16'(30 + i), 16'd1, 1'b0, 8'h00, (i == 0) ? 8'h06 : 8'h00, 1'b0);
         cyc();
      end
      in_pkt = mk(16'd33, 16'd1, 1'b0, 8'h00, 8'h00, 1'b0);
      ecr_read_data = 2'b10;
      settle();
      chk("t3_occ_before", a_occupancy, 3);
      chk("t3_ecr_read_en", a_ecr_read_en, 1);
      chk("t3_ecr_read_addr", a_ecr_read_addr, 2);
      chk("t3_lock_req_abort", a_alu_lock_req, 0);
      chk("t3_rf_wcommit", a_rf_wcommit, 0);
      chk("t3_ecr_wen", a_ecr_wen, 0);
      chk("t3_rf_wcommit_b", b_rf_wcommit, 0);
      cyc();
      in_valid = 1'b0; ecr_read_data = 2'b00;
      settle();
      chk("t3_flush_occ_a", a_occupancy, 0);
      chk("t3_flush_head_a", a_head_valid, 0);
      chk("t3_abort_cnt_a", a_abort_cnt, 1);
      chk("t3_commit_cnt_a", a_commit_cnt, 0);
      chk("t3_release_a", a_alu_release, 1);
      chk("t3_drop_occ_b", b_occupancy, 3);
      chk("t3_abort_cnt_b", b_abort_cnt, 1);
      chk("t3_release_b", b_alu_release, 1);
      chk("t3_next_head_b", b_head_pkt.issue_id, 31);
      chk("t3_next_commit_b", b_rf_wcommit, 1);
      chk("t3_next_lock_id_b", b_alu_lock_id, 31);

      // BEQ-style ECR commits, both predictions
      pulse_reset();
      alu_grant = 1'b0; alu_zero = 1'b1;
      in_valid = 1'b1; in_pkt = mk(16'd40, 16'd0, 1'b1, 8'h03, 8'h00, 1'b0);
      cyc();
      in_pkt = mk(16'd41, 16'd0, 1'b1, 8'h01, 8'h00, 1'b1);
      settle();
      chk("t4_no_grant_wen", a_ecr_wen, 0);
      cyc();
      in_valid = 1'b0; alu_grant = 1'b1;
      settle();
      chk("t4_wen_nt", a_ecr_wen, 1);
      chk("t4_waddr_nt", a_ecr_waddr, 3);
      chk("t4_wdata_nt", a_ecr_wdata, 2'b10);
      chk("t4_no_rf_write", a_rf_wcommit, 0);
      cyc(); settle();
      chk("t4_wen_t", a_ecr_wen, 1);
      chk("t4_waddr_t", a_ecr_waddr, 1);
      chk("t4_wdata_t", a_ecr_wdata, 2'b01);
      cyc();

      // async reset in the middle of a stall
      rs_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_pkt = mk(16'(50 + i), 16'd0, 1'b0, 8'h00, 8'h00, 1'b0);
         cyc();
      end
      in_valid = 1'b0;
      settle();
      chk("t5_occ_stall", a_occupancy, 2);
      rst_n = 1'b0;
      #1;
      chk("t5_async_occ", a_occupancy, 0);
      chk("t5_async_head", a_head_valid, 0);
      chk("t5_async_ready", a_in_ready, 1);
      chk("t5_async_lock", a_alu_lock_req, 0);
      chk("t5_async_cnt_a", a_commit_cnt, 0);
      chk("t5_async_cnt_b", b_commit_cnt, 0);
      chk("t5_async_abort", a_abort_cnt, 0);
      rst_n = 1'b1;
      cyc();

      // reset landing on a committing cycle must not produce a release
      rs_valid = 1'b1;
      in_valid = 1'b1; in_pkt = mk(16'd60, 16'd0, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc();
      in_valid = 1'b0;
      settle();
      chk("t6_commit_live", a_rf_wcommit, 1);
      rst_n = 1'b0;
      cyc(); settle();
      chk("t6_no_release", a_alu_release, 0);
      chk("t6_cnt_cleared", a_commit_cnt, 0);
      rst_n = 1'b1;
      cyc();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/sic_exec_alu_q.md
# sic_exec_alu_q

Parametrised successor to the single-slot SIC ALU executor. It holds up to DEPTH issued packets in an in-order queue, executes and commits the head through the shared ALU lock, RF commit port and ECR table, and aborts on branch mispredict with a selectable flush scope. It exposes valid/ready backpressure toward issue and saturating commit/abort counters. It sits between the issue stage and the shared ALU / register-file / ECR resources, one instance per SIC.

## Interface
Parameters:
- SIC_ID, 0, instance number (debug only)
- NUM_PHY_REGS, 64, physical register count (packet type parameter)
- NUM_ECRS, 4, ECR table size; ECR_W = NUM_ECRS>1 ? $clog2(NUM_ECRS) : 1
- ID_WIDTH, 8, issue_id width
- DEPTH, 4, queue entries; power of two, ≥2
- FLUSH_ALL, 1, 1 = mispredict flushes whole queue; 0 = drops head only
- CNT_W, 16, counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  issue offers in_pkt
- in_ready  out  1  queue can accept
- in_pkt  in  sic_packet_t  issued packet
- head_valid  out  1  queue non-empty
- head_pkt  out  sic_packet_t  head entry (drives RF read lookup)
- rs_valid, rt_valid  in  1 each  operand ready for head
- rs_rdata, rt_rdata  in  32 each  operand data
- ecr_read_en  out  1; ecr_read_addr  out  ECR_W; ecr_read_data  in  2
- alu_lock_req  out  1; alu_lock_id  out  ID_WIDTH; alu_release  out  1; alu_grant  in  1
- alu_op  out  alu_op_t; alu_a, alu_b  out  32; alu_c  in  32; alu_zero  in  1
- rf_wcommit  out  1; rf_wdata  out  32
- ecr_wen  out  1; ecr_waddr  out  ECR_W; ecr_wdata  out  2
- occupancy  out  $clog2(DEPTH+1)  entries held
- commit_cnt, abort_cnt  out  CNT_W  saturating event counters

## Operation
- Circular buffer, rd/wr pointers $clog2(DEPTH) bits wrap modulo DEPTH; count register 0..DEPTH.
- in_ready = (count < DEPTH); registered count only, no pass-through when full even if head commits.
- Head decode (all gated by head_valid): need_alu = use_alu; rf_ok = (!read_rs|rs_valid)&(!read_rt|rt_valid); dep = dep_ecr_id[ECR_W] (valid bit), id = dep_ecr_id[ECR_W-1:0].
- ecr_read_en = head_valid & dep; ecr_read_addr = id. ECR encoding: 01 resolved-correct, 10 mispredict, 00/11 pending.
- abort = ecr_read_en & (ecr_read_data==10). ecr_ok = !dep | (ecr_read_data==01).
- alu_lock_req = head_valid & need_alu & !abort; alu_lock_id = head issue_id. alu_op = head alu_op; alu_a = rs_rdata; alu_b = alu_b_is_imm ? (zero_ext ? imm16_zero_ext : imm16_sign_ext) : rt_rdata.
- commit = head_valid & rf_ok & ecr_ok & (!need_alu | alu_grant) & !abort.
- rf_wcommit = commit & write_gpr & (wb_sel==WB_ALU); rf_wdata = alu_c.
- ecr_wen = commit & write_ecr; ecr_waddr = set_ecr_id[ECR_W-1:0]; ecr_wdata = (alu_zero==pred_taken) ? 01 : 10.
- Commit pops head. Abort: FLUSH_ALL=0 pops head; FLUSH_ALL=1 clears queue (count←0, rd←wr) and discards any same-cycle enqueue.
- alu_release: registered pulse, 1 cycle, asserted the cycle after commit or abort of a head with need_alu=1.
- Counters: commit_cnt += commit, abort_cnt += abort; hold at 2^CNT_W−1.

## Timing
- Reset: queue empty, pointers/count 0, alu_release 0, counters 0. Hence in_ready=1, head_valid=0, occupancy=0, all request/enable outputs 0.
- Enqueue at edge t (in_valid&in_ready): entry visible as head from t+1; earliest commit in cycle t+1 (zero-wait ALU grant).
- Back-to-back: one commit per cycle max; ALU heads commit at most every cycle grant allows; release pulses may be consecutive.
- Enqueue+pop same cycle: count unchanged. Enqueue on full: ignored (in_ready=0).
- Reset mid-operation: all entries dropped, no alu_release issued.

## Test plan
- Single ALU op, rs ready, grant in same cycle, DEPTH=4: enqueue ADD rs=5 imm=3 -> rf_wcommit=1, rf_wdata=8 next cycle; alu_release 1 cycle later; commit_cnt=1.
- Fill: 4 enqueues with rs_valid=0 -> in_ready=0, occupancy=4; 5th offer not accepted; raise rs_valid+grant -> 4 commits in 4 cycles in issue order.
- Mispredict FLUSH_ALL=1: 3 entries, head dep ECR 2 reads 10, enqueue same cycle -> occupancy 0, no rf_wcommit/ecr_wen, abort_cnt=1, alu_release 1 if head need_alu.
- Mispredict FLUSH_ALL=0: same stimulus -> occupancy 3 (head dropped, enqueue kept), next head proceeds.
- BEQ commit: write_ecr=1, pred_taken=0, alu_zero=1 -> ecr_wen=1, ecr_wdata=10; pred_taken=1 -> 01.
- CNT_W=2: 5 commits -> commit_cnt saturates at 3; async reset mid-stall -> all outputs at reset values immediately.
